// File: rtl/oppm_tx.sv
// oppm_tx: OPPM line transmitter that sends a preamble, then the packet as N_MOD-bit slot symbols.
// Define OPPM_TX_PARITY_EN to append one XOR-parity trailer symbol per frame.
module oppm_tx #(
    parameter int unsigned PULSE_CT = 1,
    parameter int unsigned N_MOD    = 2,
    parameter int unsigned L        = 4,
    parameter int unsigned N_PKT    = 8,
    parameter int unsigned PRE_CT   = 3,
    parameter int unsigned PRE_SYM  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_PKT-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             pulse
);
    localparam int unsigned T     = (32'd1 << N_MOD) * L;
    localparam int unsigned N_SYM = N_PKT / ((N_MOD > 0) ? N_MOD : 1);
    localparam int unsigned CMAX  = (PRE_CT > N_SYM) ? PRE_CT : N_SYM;
    localparam int unsigned TW    = (T > 1) ? $clog2(T) : 1;
    localparam int unsigned CW    = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PREAM = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
`ifdef OPPM_TX_PARITY_EN
    localparam logic [1:0] TRAIL = 2'd3;
`endif

    if (N_MOD < 1) begin : g_bad_n_mod
        $error("oppm_tx: N_MOD must be at least 1");
    end
    if (L < 1) begin : g_bad_l
        $error("oppm_tx: L must be at least 1");
    end
    if (PULSE_CT < 1 || PULSE_CT > L) begin : g_bad_pulse_ct
        $error("oppm_tx: PULSE_CT must be in 1..L");
    end
    if (N_PKT < N_MOD || (N_MOD > 0 && (N_PKT % N_MOD) != 0)) begin : g_bad_n_pkt
        $error("oppm_tx: N_PKT must be a non-zero multiple of N_MOD");
    end
    if (PRE_CT < 1) begin : g_bad_pre_ct
        $error("oppm_tx: PRE_CT must be at least 1");
    end
    if (PRE_SYM >= (32'd1 << N_MOD)) begin : g_bad_pre_sym
        $error("oppm_tx: PRE_SYM must be below 2**N_MOD");
    end

    logic [1:0]       state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_PKT-1:0] data_q, data_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pulse_q, pulse_d;
    logic             sym_end;
    logic [N_MOD-1:0] sym_nxt;
`ifdef OPPM_TX_PARITY_EN
    logic [N_MOD-1:0] par_q, par_d;
`endif

    // Next-state logic, then outputs decoded from the next state so they leave a flop.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        sym_nxt = '0;
        sym_end = (tick_q == TW'(T - 1));
`ifdef OPPM_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = PREAM;
                    tick_d  = '0;
                    cnt_d   = '0;
                    data_d  = data;
`ifdef OPPM_TX_PARITY_EN
                    par_d   = '0;
`endif
                end
            end
            PREAM: begin
                tick_d = sym_end ? '0 : tick_q + TW'(1);
                if (sym_end) begin
                    if (cnt_q == CW'(PRE_CT - 1)) begin
                        cnt_d   = '0;
                        state_d = DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DATA: begin
                tick_d = sym_end ? '0 : tick_q + TW'(1);
                if (sym_end) begin
                    data_d = data_q << N_MOD;
`ifdef OPPM_TX_PARITY_EN
                    par_d  = par_q ^ data_q[N_PKT-1 -: N_MOD];
`endif
                    if (cnt_q == CW'(N_SYM - 1)) begin
                        cnt_d   = '0;
`ifdef OPPM_TX_PARITY_EN
                        state_d = TRAIL;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`ifdef OPPM_TX_PARITY_EN
            TRAIL: begin
                tick_d = sym_end ? '0 : tick_q + TW'(1);
                if (sym_end) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        case (state_d)
            PREAM:   sym_nxt = N_MOD'(PRE_SYM);
            DATA:    sym_nxt = data_d[N_PKT-1 -: N_MOD];
`ifdef OPPM_TX_PARITY_EN
            TRAIL:   sym_nxt = par_d;
`endif
            default: sym_nxt = '0;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = !ready_d;
        pulse_d = busy_d
                  && (32'(tick_d) >= 32'(sym_nxt) * L)
                  && (32'(tick_d) < 32'(sym_nxt) * L + PULSE_CT);
`ifdef OPPM_TX_PARITY_EN
        done_d  = (state_d == TRAIL) && (tick_d == TW'(T - 1));
`else
        done_d  = (state_d == DATA) && (cnt_d == CW'(N_SYM - 1)) && (tick_d == TW'(T - 1));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
`ifdef OPPM_TX_PARITY_EN
            par_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pulse_q <= pulse_d;
`ifdef OPPM_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign pulse = pulse_q;

endmodule

// File: tb/tb_oppm_tx.sv
// tb_oppm_tx: frame-offset reference model for oppm_tx, checked every cycle on two configurations.
// Honours OPPM_TX_PARITY_EN in the same way as the design.
module tb_oppm_tx;
    localparam int N_PKT  = 8;
    localparam int N_MOD  = 2;
    localparam int L      = 4;
    localparam int PRE_CT = 3;
    localparam int NS     = N_PKT / N_MOD;
    localparam int T      = (1 << N_MOD) * L;
`ifdef OPPM_TX_PARITY_EN
    localparam int PAR      = 1;
    localparam int DONE_LIT = 128;
`else
    localparam int PAR      = 0;
    localparam int DONE_LIT = 112;
`endif
    localparam int FLEN  = (PRE_CT + NS + PAR) * T;
    localparam int REC_N = 200;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid = 1'b0;
    logic [N_PKT-1:0] data = '0;
    logic             ready, busy, done, pulse;
    logic             ready4, busy4, done4, pulse4;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    oppm_tx u_dut (
        .clk(clk), .rst(rst), .data(data), .valid(valid),
        .ready(ready), .busy(busy), .done(done), .pulse(pulse)
    );

    oppm_tx #(.PULSE_CT(4), .L(4), .PRE_SYM(2)) u_dut4 (
        .clk(clk), .rst(rst), .data(data), .valid(valid),
        .ready(ready4), .busy(busy4), .done(done4), .pulse(pulse4)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int data_sym(input logic [N_PKT-1:0] p, input int j);
        logic [N_PKT-1:0] sh;
        sh = p >> (N_PKT - N_MOD * (j + 1));
        return int'(sh[N_MOD-1:0]);
    endfunction

    // Symbol index si of a frame: preamble, packet symbols MSB first, then parity.
    function automatic int sym_at(input int si, input logic [N_PKT-1:0] p, input int psym);
        int s;
        s = 0;
        if (si < PRE_CT) s = psym;
        else if (si < PRE_CT + NS) s = data_sym(p, si - PRE_CT);
        else for (int j = 0; j < NS; j++) s = s ^ data_sym(p, j);
        return s;
    endfunction

    function automatic logic exp_pulse(input int off, input logic [N_PKT-1:0] p,
                                       input int pct, input int psym);
        int t, s;
        t = off % T;
        s = sym_at(off / T, p, psym);
        return (t >= s * L) && (t < s * L + pct);
    endfunction

    // Model: m_off is the frame cycle index (0..FLEN-1) of the cycle now starting.
    bit               m_act = 1'b0;
    int               m_off = 0;
    logic [N_PKT-1:0] m_pkt = '0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_act = 1'b0;
        end else if (m_act) begin
            m_off = m_off + 1;
            if (m_off == FLEN) m_act = 1'b0;
        end else if (valid) begin
            m_act = 1'b1;
            m_off = 0;
            m_pkt = data;
        end
    end

    bit rec_on = 1'b0;
    int rec_k = 0;
    bit rec_p [REC_N];
    bit rec_p4[REC_N];
    bit rec_r [REC_N];
    bit rec_b [REC_N];
    bit rec_d [REC_N];

    always @(negedge clk) begin
        logic er, eb, ed, ep, ep4;
        int   idx;
        if (chk_en) begin
            if (m_act) begin
                er  = 1'b0;
                eb  = 1'b1;
                ed  = (m_off == FLEN - 1);
                ep  = exp_pulse(m_off, m_pkt, 1, 0);
                ep4 = exp_pulse(m_off, m_pkt, 4, 2);
            end else begin
                {er, eb, ed, ep, ep4} = 5'b10000;
            end
            chk("ready", ready, er);
            chk("busy", busy, eb);
            chk("done", done, ed);
            chk("pulse", pulse, ep);
            chk("ready4", ready4, er);
            chk("busy4", busy4, eb);
            chk("done4", done4, ed);
            chk("pulse4", pulse4, ep4);
        end
        idx = cyc - rec_k;
        if (rec_on && idx >= 0 && idx < REC_N) begin
            rec_p[idx]  = pulse;
            rec_p4[idx] = pulse4;
            rec_r[idx]  = ready;
            rec_b[idx]  = busy;
            rec_d[idx]  = done;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_rec();
        for (int i = 0; i < REC_N; i++) begin
            rec_p[i] = 0; rec_p4[i] = 0; rec_r[i] = 0; rec_b[i] = 0; rec_d[i] = 0;
        end
        rec_k  = cyc;
        rec_on = 1'b1;
    endtask

    function automatic int count_ones(input int which, input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) begin
            case (which)
                0:       n += int'(rec_p[i]);
                1:       n += int'(rec_p4[i]);
                2:       n += int'(rec_r[i]);
                default: n += int'(rec_d[i]);
            endcase
        end
        return n;
    endfunction

    initial begin
        int b7_pos[$];
        int ff_pos[$];

        rst = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        step();
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pulse", pulse, 1'b0);
        rst = 1'b0;
        repeat (3) step();

        // Packet B7 -> symbols 2,3,1,3; data changes after acceptance must be ignored.
        data = 8'hB7;
        valid = 1'b1;
        start_rec();
        step();
        valid = 1'b0;
        data = 8'h00;
        repeat (FLEN + 4) step();
        rec_on = 1'b0;
        b7_pos = '{1, 17, 33, 57, 77, 85, 109};
`ifdef OPPM_TX_PARITY_EN
        b7_pos.push_back(125);
`endif
        foreach (b7_pos[i]) chk("b7_pulse_pos", rec_p[b7_pos[i]], 1'b1);
        chk_int("b7_pulse_count", count_ones(0, 1, DONE_LIT + 2), b7_pos.size());
        chk("b7_done_pos", rec_d[DONE_LIT], 1'b1);
        chk_int("b7_done_count", count_ones(3, 0, DONE_LIT + 3), 1);
        chk_int("b7_ready_low", count_ones(2, 1, DONE_LIT), 0);
        chk("b7_ready_rise", rec_r[DONE_LIT + 1], 1'b1);

        // Packet FF on the wide-pulse instance: 4-cycle pulses at t=12..15 of each data symbol.
        data = 8'hFF;
        valid = 1'b1;
        start_rec();
        step();
        valid = 1'b0;
        data = 8'h3C;
        repeat (FLEN + 4) step();
        rec_on = 1'b0;
        ff_pos = '{61, 62, 63, 64, 77, 78, 79, 80, 93, 94, 95, 96, 109, 110, 111, 112};
        foreach (ff_pos[i]) chk("ff_pulse4_pos", rec_p4[ff_pos[i]], 1'b1);
        chk_int("ff_pulse4_count", count_ones(1, 49, 112), 16);
        chk("ff_pulse4_gap", rec_p4[65], 1'b0);

        // Reset at k+40, then a fresh packet at k+42.
        data = 8'hC3;
        valid = 1'b1;
        start_rec();
        step();
        valid = 1'b0;
        repeat (39) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        data = 8'h5A;
        valid = 1'b1;
        step();
        valid = 1'b0;
        repeat (FLEN + 4) step();
        rec_on = 1'b0;
        chk("rst_mid_ready", rec_r[41], 1'b1);
        chk("rst_mid_busy", rec_b[41], 1'b0);
        chk("rst_mid_pulse", rec_p[41], 1'b0);
        chk_int("rst_mid_no_done", count_ones(3, 0, 41), 0);
        chk("rst_new_busy", rec_b[43], 1'b1);
        chk("rst_new_done", rec_d[42 + FLEN], 1'b1);

        // valid held high with data changing every cycle.
        valid = 1'b1;
        for (int i = 0; i < 3 * FLEN + 10; i++) begin
            data = 8'($urandom);
            step();
        end
        valid = 1'b0;
        repeat (FLEN + 4) step();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            valid = ($urandom_range(0, 2) == 0);
            data = 8'($urandom);
            step();
        end
        rst = 1'b0;
        valid = 1'b0;
        repeat (FLEN + 4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
